// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage pipeline.
//
// Drives the enable (hold) and flush pins of the PC, IF/ID, ID/EX, EX/MEM
// and MEM/WB registers. It handles:
//   - load-use bubbles
//   - EX-stage redirects with an optional multi-cycle IF/ID flush drain
//   - data-memory wait freezes with a sticky timeout flag
//
// Optional feature macro: HAZARD_PERF_EN
//   Defined:   o_stall_cnt and o_flush_cnt are live saturating counters.
//   Undefined: both ports are tied to zero and no counter flops exist.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_id_rs1/_rs2, *_used     ID-stage source registers and their use flags
//   i_ex_rd, i_ex_mem_read    EX-stage destination register and load flag
//   i_ex_redirect             EX resolved a taken branch/jump this cycle
//   i_dmem_wait               data memory not ready, MEM must hold
//   o_pc_en, o_*_en           register load enables (0 = hold)
//   o_if_id_flush,
//   o_id_ex_flush             register flushes
//   o_mem_timeout             sticky dmem wait timeout flag
//   o_state                   registered FSM state (debug)
//   o_stall_cnt, o_flush_cnt  performance counters (see macro above)
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned FLUSH_EXTRA = 1,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_redirect,
  input  logic                  i_dmem_wait,
  output logic                  o_pc_en,
  output logic                  o_if_id_en,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_en,
  output logic                  o_id_ex_flush,
  output logic                  o_ex_mem_en,
  output logic                  o_mem_wb_en,
  output logic                  o_mem_timeout,
  output logic [1:0]            o_state,
  output logic [31:0]           o_stall_cnt,
  output logic [31:0]           o_flush_cnt
);

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StRedirect = 2'd1,
    StMemWait  = 2'd2
  } state_e;

  localparam logic [2:0] FlushExtra = 3'(FLUSH_EXTRA);
  localparam bit         DrainEn    = (FLUSH_EXTRA != 0);
  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);
  localparam bit         TimeoutEn  = (MEM_TIMEOUT != 0);

  state_e     state_q, state_d;
  logic [2:0] dcnt_q, dcnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       timeout_q, timeout_d;
  logic       load_use_hit;

  assign load_use_hit = i_ex_mem_read && (i_ex_rd != '0) &&
                        ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StRun;
      dcnt_q    <= '0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    wcnt_d        = wcnt_q;
    timeout_d     = timeout_q;
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_en    = 1'b1;
    o_id_ex_flush = 1'b0;
    o_ex_mem_en   = 1'b1;
    o_mem_wb_en   = 1'b1;

    if (i_reset) begin
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_if_id_flush = 1'b1;
      o_id_ex_en    = 1'b0;
      o_id_ex_flush = 1'b1;
      o_ex_mem_en   = 1'b0;
      o_mem_wb_en   = 1'b0;
    end else if (i_dmem_wait) begin
      // Whole pipe freezes; dcnt is kept so a pending drain resumes afterwards.
      o_pc_en     = 1'b0;
      o_if_id_en  = 1'b0;
      o_id_ex_en  = 1'b0;
      o_ex_mem_en = 1'b0;
      o_mem_wb_en = 1'b0;
      state_d     = StMemWait;
      if (wcnt_q != 8'hFF) begin
        wcnt_d = wcnt_q + 8'd1;
      end
      if (TimeoutEn && (wcnt_d == TimeoutCnt)) begin
        timeout_d = 1'b1;
      end
    end else begin
      wcnt_d = '0;
      // Exit cycle out of MEM_WAIT: resume an interrupted drain if one is pending.
      if (state_q == StMemWait) begin
        state_d = (dcnt_q != '0) ? StRedirect : StRun;
      end

      if (i_ex_redirect) begin
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
        if (DrainEn) begin
          dcnt_d  = FlushExtra;
          state_d = StRedirect;
        end else begin
          state_d = StRun;
        end
      end else if (state_q == StRedirect) begin
        // Drain: wrong-path fetches keep getting squashed at IF/ID.
        o_if_id_flush = 1'b1;
        if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - 3'd1;
        end
        state_d = (dcnt_q <= 3'd1) ? StRun : StRedirect;
      end else if (load_use_hit) begin
        // One bubble: hold PC and IF/ID, squash the instruction entering EX.
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_id_ex_flush = 1'b1;
      end
    end
  end

  assign o_mem_timeout = timeout_q;
  assign o_state       = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!o_pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (i_ex_redirect && !i_dmem_wait && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (FLUSH_EXTRA=2, MEM_TIMEOUT=3).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       rs1_used, rs2_used, ex_mem_read, ex_redirect, dmem_wait;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic       mem_timeout;
  logic [1:0] state;
  logic [31:0] stall_cnt, flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Control vector order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb
  localparam logic [6:0] CRst   = 7'b0010100;
  localparam logic [6:0] CRun   = 7'b1101011;
  localparam logic [6:0] CLu    = 7'b0001111;
  localparam logic [6:0] CRedir = 7'b1111111;
  localparam logic [6:0] CDrain = 7'b1111011;
  localparam logic [6:0] CFrz   = 7'b0000000;

`ifdef HAZARD_PERF_EN
  localparam logic [31:0] ExpStall = 32'd5;
  localparam logic [31:0] ExpFlush = 32'd1;
`else
  localparam logic [31:0] ExpStall = 32'd0;
  localparam logic [31:0] ExpFlush = 32'd0;
`endif

  hazard_ctrl #(
    .REG_ADDR_W (5),
    .FLUSH_EXTRA(2),
    .MEM_TIMEOUT(3)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_rs1_used(rs1_used),
    .i_id_rs2_used(rs2_used),
    .i_ex_rd      (ex_rd),
    .i_ex_mem_read(ex_mem_read),
    .i_ex_redirect(ex_redirect),
    .i_dmem_wait  (dmem_wait),
    .o_pc_en      (pc_en),
    .o_if_id_en   (if_id_en),
    .o_if_id_flush(if_id_flush),
    .o_id_ex_en   (id_ex_en),
    .o_id_ex_flush(id_ex_flush),
    .o_ex_mem_en  (ex_mem_en),
    .o_mem_wb_en  (mem_wb_en),
    .o_mem_timeout(mem_timeout),
    .o_state      (state),
    .o_stall_cnt  (stall_cnt),
    .o_flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle, then advance to the next falling edge.
  task automatic step(input string tag, input logic [6:0] e_ctl, input logic [1:0] e_st,
                      input logic e_to);
    #1;
    check({tag, ".ctl"}, 32'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                              ex_mem_en, mem_wb_en}), 32'(e_ctl));
    check({tag, ".state"}, 32'(state), 32'(e_st));
    check({tag, ".timeout"}, 32'(mem_timeout), 32'(e_to));
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    rs1_used = 0; rs2_used = 0; ex_mem_read = 0; ex_redirect = 0; dmem_wait = 0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
    ex_mem_read = 1; ex_rd = rd; id_rs1 = r1; rs1_used = u1; id_rs2 = r2; rs2_used = u2;
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);

    // Reset held 3 cycles, then released.
    step("rst_a", CRst, 2'd0, 0);
    step("rst_b", CRst, 2'd0, 0);
    step("rst_c", CRst, 2'd0, 0);
    rst = 0;
    step("rel", CRun, 2'd0, 0);

    // Load-use variants.
    load_use(5'd5, 5'd0, 0, 5'd5, 1); step("lu_rs2", CLu, 2'd0, 0);
    idle();                           step("lu_clr", CRun, 2'd0, 0);
    load_use(5'd0, 5'd0, 0, 5'd0, 1); step("lu_x0", CRun, 2'd0, 0);
    load_use(5'd7, 5'd7, 1, 5'd3, 0); step("lu_rs1", CLu, 2'd0, 0);
    load_use(5'd7, 5'd7, 0, 5'd7, 0); step("lu_unused", CRun, 2'd0, 0);
    load_use(5'd9, 5'd9, 1, 5'd0, 0); ex_mem_read = 0;
    step("lu_noload", CRun, 2'd0, 0);

    // Redirect with 2-cycle drain; load-use is ignored while draining.
    idle(); ex_redirect = 1;          step("rd_c0", CRedir, 2'd0, 0);
    idle(); load_use(5'd4, 5'd4, 1, 5'd0, 0);
    step("rd_c1", CDrain, 2'd1, 0);
    idle();                           step("rd_c2", CDrain, 2'd1, 0);
    step("rd_c3", CRun, 2'd0, 0);

    // Second redirect in the first drain cycle reloads the drain.
    ex_redirect = 1;                  step("rr_c0", CRedir, 2'd0, 0);
    ex_redirect = 1;                  step("rr_c1", CRedir, 2'd1, 0);
    idle();                           step("rr_c2", CDrain, 2'd1, 0);
    step("rr_c3", CDrain, 2'd1, 0);
    step("rr_c4", CRun, 2'd0, 0);

    // Timeout after 3 wait cycles, sticky afterwards.
    dmem_wait = 1;                    step("to_w1", CFrz, 2'd0, 0);
    load_use(5'd5, 5'd5, 1, 5'd0, 0); step("to_w2", CFrz, 2'd2, 0);
    idle(); dmem_wait = 1;            step("to_w3", CFrz, 2'd2, 0);
    step("to_w4", CFrz, 2'd2, 1);
    step("to_w5", CFrz, 2'd2, 1);
    dmem_wait = 0;                    step("to_exit", CRun, 2'd2, 1);
    step("to_after", CRun, 2'd0, 1);

    // Synchronous reset clears the flag at the edge, not immediately.
    rst = 1;                          step("rst2_a", CRst, 2'd0, 1);
    step("rst2_b", CRst, 2'd0, 0);
    rst = 0;                          step("rel2", CRun, 2'd0, 0);

    // Wait during drain (dcnt=1); redirect during wait is ignored.
    ex_redirect = 1;                  step("wd_rd", CRedir, 2'd0, 0);
    idle();                           step("wd_d1", CDrain, 2'd1, 0);
    dmem_wait = 1; ex_redirect = 1;   step("wd_w1", CFrz, 2'd1, 0);
    ex_redirect = 0;                  step("wd_w2", CFrz, 2'd2, 0);
    step("wd_w3", CFrz, 2'd2, 0);
    step("wd_w4", CFrz, 2'd2, 1);
    dmem_wait = 0;                    step("wd_exit", CRun, 2'd2, 1);
    step("wd_drain", CDrain, 2'd1, 1);
    step("wd_run", CRun, 2'd0, 1);

    // Performance counters: 2 bubbles + 3 wait cycles + 1 redirect.
    rst = 1;                          step("rst3_a", CRst, 2'd0, 1);
    step("rst3_b", CRst, 2'd0, 0);
    rst = 0;                          step("rel3", CRun, 2'd0, 0);
    check("stall_zero", stall_cnt, 32'd0);
    check("flush_zero", flush_cnt, 32'd0);
    load_use(5'd6, 5'd0, 0, 5'd6, 1); step("pf_lu1", CLu, 2'd0, 0);
    idle();                           step("pf_i1", CRun, 2'd0, 0);
    load_use(5'd2, 5'd2, 1, 5'd0, 0); step("pf_lu2", CLu, 2'd0, 0);
    idle();                           step("pf_i2", CRun, 2'd0, 0);
    dmem_wait = 1;                    step("pf_w1", CFrz, 2'd0, 0);
    step("pf_w2", CFrz, 2'd2, 0);
    step("pf_w3", CFrz, 2'd2, 0);
    dmem_wait = 0;                    step("pf_exit", CRun, 2'd2, 1);
    ex_redirect = 1;                  step("pf_rd", CRedir, 2'd0, 1);
    idle();                           step("pf_d1", CDrain, 2'd1, 1);
    step("pf_d2", CDrain, 2'd1, 1);
    step("pf_run", CRun, 2'd0, 1);
    check("stall_cnt", stall_cnt, ExpStall);
    check("flush_cnt", flush_cnt, ExpFlush);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller. Generates the enable (stall) and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Detects load-use hazards, EX-stage control redirects and data-memory wait states.
- Sequences multi-cycle flush drains and a data-memory wait timeout.
- Sits beside the 5-stage pipeline datapath, driving the register-side enable/flush pins.

Parameters:
REG_ADDR_W, 5, register address width
FLUSH_EXTRA, 1, extra cycles IF/ID stays flushed after a redirect (0..7)
MEM_TIMEOUT, 255, max consecutive dmem wait cycles before timeout flag; 0 disables timeout

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_id_rs1  in  REG_ADDR_W  ID-stage source 1 address
i_id_rs2  in  REG_ADDR_W  ID-stage source 2 address
i_id_rs1_used  in  1  ID instruction reads rs1
i_id_rs2_used  in  1  ID instruction reads rs2
i_ex_rd  in  REG_ADDR_W  EX-stage destination address
i_ex_mem_read  in  1  EX instruction is a load
i_ex_redirect  in  1  EX resolved taken branch/jump; PC mux selects target this cycle
i_dmem_wait  in  1  data memory not ready; MEM stage must hold
o_pc_en  out  1  PC register load enable
o_if_id_en  out  1  IF/ID enable (0 = hold)
o_if_id_flush  out  1  IF/ID flush
o_id_ex_en  out  1  ID/EX enable
o_id_ex_flush  out  1  ID/EX flush
o_ex_mem_en  out  1  EX/MEM enable
o_mem_wb_en  out  1  MEM/WB enable
o_mem_timeout  out  1  sticky dmem timeout flag
o_state  out  2  current FSM state (debug)

Behaviour:
- States: RUN=0, REDIRECT=1, MEM_WAIT=2. Registered state, drain counter `dcnt` (3 bits) and wait counter `wcnt` (8 bits, saturating). Outputs are combinational from state + current inputs.
- Reset (i_reset=1 at posedge):
  - state=RUN, dcnt=0, wcnt=0, o_mem_timeout=0.
  - While i_reset is high: all *_en=0, both flushes=1.
- Load-use hit: i_ex_mem_read && i_ex_rd!=0 && ((i_id_rs1_used && i_id_rs1==i_ex_rd) || (i_id_rs2_used && i_id_rs2==i_ex_rd)).
- Condition priority, highest first:
  1. i_dmem_wait
     - All enables=0, no flushes; the whole pipe freezes.
     - Next state=MEM_WAIT. dcnt and a pending redirect drain are preserved.
     - wcnt increments, saturating at 255.
     - If MEM_TIMEOUT!=0 and wcnt reaches MEM_TIMEOUT, o_mem_timeout sets and stays set until reset.
  2. i_ex_redirect
     - pc_en=1, if_id_flush=1, id_ex_flush=1, other enables=1.
     - If FLUSH_EXTRA>0: dcnt<=FLUSH_EXTRA, next state=REDIRECT. Otherwise state stays RUN.
     - A new redirect while in REDIRECT reloads dcnt.
  3. REDIRECT drain (state=REDIRECT, no redirect)
     - if_id_flush=1; all enables=1.
     - dcnt decrements each cycle; return to RUN when dcnt reaches 0 (i.e. exactly FLUSH_EXTRA drain cycles).
     - Load-use detection is suppressed in this state.
  4. Load-use
     - pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=1, mem_wb_en=1.
     - Exactly one bubble per hazard; the hit naturally clears the next cycle once the load has moved to MEM.
  5. Otherwise: all enables=1, flushes=0.
- Leaving MEM_WAIT (i_dmem_wait low):
  - wcnt clears.
  - Next state=REDIRECT if dcnt!=0, else RUN.
  - In the exit cycle, priorities 2–5 are evaluated normally.
- Flush and enable on the same register: flush wins by construction at the register; this block never asserts if_id_flush with if_id_en=0 except during reset.
- o_state reflects the registered state.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs o_stall_cnt[31:0] and o_flush_cnt[31:0], both saturating at 32'hFFFFFFFF and cleared on reset.
  - o_stall_cnt counts cycles with o_pc_en=0 outside reset.
  - o_flush_cnt counts cycles with i_ex_redirect=1 and i_dmem_wait=0.
- Undefined: the ports still exist, are tied to 0, and no counter flops are generated.

Test Plan:
- Reset held 3 cycles, then released with idle inputs -> during reset all en=0 and flushes=1; first cycle after release: all en=1, flushes=0, o_state=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, rs2_used=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle only. Repeat with ex_rd=0 -> no stall.
- Redirect pulse with FLUSH_EXTRA=2 -> cycle 0: if_id_flush=1 and id_ex_flush=1; cycles 1–2: if_id_flush=1 only, o_state=1; cycle 3: RUN with no flushes. Second redirect at cycle 1 -> drain extends to cycle 3.
- dmem_wait asserted 4 cycles during REDIRECT drain (dcnt=1) -> all en=0 and no flushes for 4 cycles, o_state=2; after release, 1 remaining drain cycle, then RUN.
- MEM_TIMEOUT=3, dmem_wait held 5 cycles -> o_mem_timeout rises after the 3rd wait cycle and stays 1 after wait drops, until i_reset.
- HAZARD_PERF_EN defined: 2 load-use bubbles + 3 wait cycles + 1 redirect -> o_stall_cnt=5, o_flush_cnt=1.
